// File: rtl/mem_slot_dumper_pkg.sv
// mem_slot_dumper_pkg: shared state encodings, defaults and log2 helper for slot walkers
package mem_slot_dumper_pkg;
  localparam int DEF_WORDSZ_BYTES = 4;
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_e;
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/mem_slot_dumper_slot_counter.sv
// mem_slot_dumper_slot_counter: slot index walker with clear, increment and last-slot flag
module mem_slot_dumper_slot_counter
  import mem_slot_dumper_pkg::*;
#(
  parameter int N  = 32,
  parameter int SW = log2(N)
) (
  input  logic          _clk,
  input  logic          _reset_n,
  input  logic          _clr,
  input  logic          _inc,
  output logic [SW-1:0] slot_,
  output logic          last_
);
  // slot index: clear wins over increment
  always_ff @(posedge _clk or negedge _reset_n)
    if (!_reset_n) slot_ <= '0;
    else if (_clr) slot_ <= '0;
    else if (_inc) slot_ <= slot_ + 1'b1;
  assign last_ = slot_ == SW'(N - 1);
endmodule

// File: rtl/mem_slot_dumper.sv
// mem_slot_dumper: walks all memory slots and streams (vptr, data) pairs over valid/ready
module mem_slot_dumper
  import mem_slot_dumper_pkg::*;
#(
  parameter int MEM_SLOTS_COUNT = 32,
  parameter int WORDSZ_BYTES    = DEF_WORDSZ_BYTES,
  parameter int SW              = log2(MEM_SLOTS_COUNT)
) (
  input  logic          _clk,
  input  logic          _reset_n,
  input  logic          _base_load,
  input  logic [31:0]   _base_vptr,
  input  logic          _start,
  input  logic          _abort,
  output logic          rd_en_,
  output logic [SW-1:0] rd_slot_n_,
  input  logic [31:0]   _rd_data,
  output logic          out_valid_,
  input  logic          _out_ready,
  output logic [31:0]   out_vptr_,
  output logic [31:0]   out_data_,
  output logic          busy_,
  output logic          done_
);
  localparam int WB = log2(WORDSZ_BYTES);
  state_e        state_q, state_d;
  logic [31:0]   base_q;
  logic [SW-1:0] slot;
  logic          last, slot_clr, slot_inc;
  mem_slot_dumper_slot_counter #(.N(MEM_SLOTS_COUNT), .SW(SW)) u_slot (
    ._clk     (_clk),
    ._reset_n (_reset_n),
    ._clr     (slot_clr),
    ._inc     (slot_inc),
    .slot_    (slot),
    .last_    (last)
  );
  // next state; an accept coincident with abort still retires the pair before DONE
  always_comb begin
    state_d  = state_q;
    slot_clr = 1'b0;
    slot_inc = 1'b0;
    case (state_q)
      S_IDLE: if (_start) begin
        state_d  = S_READ;
        slot_clr = 1'b1;
      end
      S_READ: state_d = _abort ? S_DONE : S_WAIT;
      S_WAIT: state_d = _abort ? S_DONE : S_EMIT;
      S_EMIT: if (_out_ready && !_abort && !last) begin
        state_d  = S_READ;
        slot_inc = 1'b1;
      end else if (_out_ready || _abort) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge _clk or negedge _reset_n)
    if (!_reset_n) state_q <= S_IDLE;
    else state_q <= state_d;
  // base only moves while idle so a running dump keeps a consistent address map
  always_ff @(posedge _clk or negedge _reset_n)
    if (!_reset_n) base_q <= '0;
    else if (state_q == S_IDLE && _base_load) base_q <= _base_vptr;
  // capture the read word and its address; held through EMIT until accepted
  always_ff @(posedge _clk or negedge _reset_n)
    if (!_reset_n) begin
      out_data_ <= '0;
      out_vptr_ <= '0;
    end else if (state_q == S_WAIT) begin
      out_data_ <= _rd_data;
      out_vptr_ <= base_q + (32'(slot) << WB);
    end
  assign rd_en_     = state_q == S_READ;
  assign rd_slot_n_ = rd_en_ ? slot : '0;
  assign out_valid_ = state_q == S_EMIT;
  assign busy_      = state_q != S_IDLE;
  assign done_      = state_q == S_DONE;
endmodule
